// File: rtl/mem_stream_writer.sv
// Fill controller: loads a depth x width memory at addresses 0..depth-1
// from a valid/ready word stream, then holds DONE until restarted.
module mem_stream_writer #(
   parameter  int width = 5,
   parameter  int depth = 4,
   localparam int AW    = $clog2(depth),
   localparam int CW    = $clog2(depth + 1)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [width-1:0] IN_DATA,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [width-1:0] WDATA,
   output logic [AW-1:0]    WADDR,
   output logic             WEN,
   output logic             DONE,
   output logic [CW-1:0]    COUNT
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_FULL
   } state_t;

   localparam logic [AW-1:0] LAST = AW'(depth - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [AW-1:0]    r_ptr;
   logic [AW-1:0]    w_ptr_nxt;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_count_nxt;
   logic             r_wen;
   logic [AW-1:0]    r_waddr;
   logic [width-1:0] r_wdata;
   logic             w_ready;
   logic             w_hs;
   logic             w_last;

   assign w_ready = (r_state == S_FILL) && !START;
   assign w_hs    = IN_VALID && w_ready;
   assign w_last  = (r_ptr == LAST);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_count <= w_count_nxt;
      end
   end

   // START outranks everything except reset; it can never coincide with
   // a handshake because it forces IN_READY low.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_count_nxt = r_count;
      unique case (r_state)
         S_IDLE: ;
         S_FILL: begin
            if (w_hs) begin
               w_count_nxt = r_count + CW'(1);
               if (w_last) begin
                  w_state_nxt = S_FULL;
               end else begin
                  w_ptr_nxt = r_ptr + AW'(1);
               end
            end
         end
         S_FULL: ;
         default: w_state_nxt = S_IDLE;
      endcase
      if (START) begin
         w_state_nxt = S_FILL;
         w_ptr_nxt   = '0;
         w_count_nxt = '0;
      end
   end

   // Write port is registered; address/data hold when no write is issued.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_wen   <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_wen <= w_hs;
         if (w_hs) begin
            r_waddr <= r_ptr;
            r_wdata <= IN_DATA;
         end
      end
   end

   assign IN_READY = w_ready;
   assign WEN      = r_wen;
   assign WADDR    = r_waddr;
   assign WDATA    = r_wdata;
   assign DONE     = (r_state == S_FULL);
   assign COUNT    = r_count;

endmodule
